// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier: controller states and the
// default operand/counter widths also used by the product register and ALU wrappers.
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_iter_counter.sv
// Iteration counter for the multiplier controller; terminal_o flags the enabled
// edge on which the count reaches WIDTH.
module mul_iter_counter
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] count_o,
    output logic             terminal_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Looks one step ahead so the FSM can leave RUN on the same edge the count hits WIDTH.
    assign terminal_o = enable_i && !clear_i && (count_q == CNT_W'(WIDTH - 1));
    assign count_o    = count_q;

endmodule

// File: rtl/mul_controller.sv
// Sequencing controller for the shift-add multiplier: drives product register
// load/shift/ready, holds the multiplicand, and stops after WIDTH iterations or an ALU carry.
module mul_controller
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Multiplicand_in,
    input  logic             Product_lsb,
    input  logic             ALU_carry,
    output logic             W_ctrl,
    output logic             SRL_ctrl,
    output logic             ADDU_ctrl,
    output logic             Ready,
    output logic             Busy,
    output logic             Overflow,
    output logic [WIDTH-1:0] Multiplicand_out,
    output logic [CNT_W-1:0] Count
);

    mul_state_e       state_q;
    logic             wCtrl_q;
    logic             srlCtrl_q;
    logic             ready_q;
    logic             busy_q;
    logic             overflow_q;
    logic [WIDTH-1:0] multiplicand_q;

    logic             cntClear;
    logic             cntEnable;
    logic             cntTerminal;

    assign cntClear  = (state_q == IDLE) && Run;
    assign cntEnable = (state_q == RUN);

    mul_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk        (clk),
        .Reset      (Reset),
        .clear_i    (cntClear),
        .enable_i   (cntEnable),
        .count_o    (Count),
        .terminal_o (cntTerminal)
    );

    // DONE is only left through Reset, because the product register reloads the multiplier only then.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= IDLE;
            wCtrl_q        <= 1'b1;
            srlCtrl_q      <= 1'b0;
            ready_q        <= 1'b0;
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
            multiplicand_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Run) begin
                        multiplicand_q <= Multiplicand_in;
                        state_q        <= RUN;
                        wCtrl_q        <= 1'b0;
                        srlCtrl_q      <= 1'b1;
                        busy_q         <= 1'b1;
                    end
                end
                RUN: begin
                    if (ALU_carry || cntTerminal) begin
                        state_q   <= DONE;
                        srlCtrl_q <= 1'b0;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                        if (ALU_carry) begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign W_ctrl           = wCtrl_q;
    assign SRL_ctrl         = srlCtrl_q;
    assign Ready            = ready_q;
    assign Busy             = busy_q;
    assign Overflow         = overflow_q;
    assign Multiplicand_out = multiplicand_q;
    assign ADDU_ctrl        = (state_q == RUN) && Product_lsb;

endmodule

// File: tb/tb_mul_controller.sv
// Directed self-checking bench for mul_controller.
module tb_mul_controller;

    logic        clk;
    logic        Reset;
    logic        Run;
    logic [31:0] Multiplicand_in;
    logic        Product_lsb;
    logic        ALU_carry;
    logic        W_ctrl;
    logic        SRL_ctrl;
    logic        ADDU_ctrl;
    logic        Ready;
    logic        Busy;
    logic        Overflow;
    logic [31:0] Multiplicand_out;
    logic [5:0]  Count;

    int compared   = 0;
    int mismatched = 0;

    mul_controller dut (
        .clk              (clk),
        .Reset            (Reset),
        .Run              (Run),
        .Multiplicand_in  (Multiplicand_in),
        .Product_lsb      (Product_lsb),
        .ALU_carry        (ALU_carry),
        .W_ctrl           (W_ctrl),
        .SRL_ctrl         (SRL_ctrl),
        .ADDU_ctrl        (ADDU_ctrl),
        .Ready            (Ready),
        .Busy             (Busy),
        .Overflow         (Overflow),
        .Multiplicand_out (Multiplicand_out),
        .Count            (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic w, input logic srl, input logic rdy,
                            input logic bsy, input logic ovf, input logic [5:0] cnt,
                            input logic [31:0] mc);
        checkOutput({tag, ".W_ctrl"},   64'(W_ctrl),           64'(w));
        checkOutput({tag, ".SRL_ctrl"}, 64'(SRL_ctrl),         64'(srl));
        checkOutput({tag, ".Ready"},    64'(Ready),            64'(rdy));
        checkOutput({tag, ".Busy"},     64'(Busy),             64'(bsy));
        checkOutput({tag, ".Overflow"}, 64'(Overflow),         64'(ovf));
        checkOutput({tag, ".Count"},    64'(Count),            64'(cnt));
        checkOutput({tag, ".Mcand"},    64'(Multiplicand_out), 64'(mc));
    endtask

    task automatic applyStimulus(input logic doReset, input logic [31:0] mcand);
        if (doReset) begin
            Reset = 1'b1;
            tick();
            Reset = 1'b0;
        end
        Multiplicand_in = mcand;
        Run = 1'b1;
        tick();
        Run = 1'b0;
    endtask

    initial begin
        logic [31:0] mplier;
        int          srlCycles;

        Reset           = 1'b1;
        Run             = 1'b0;
        Multiplicand_in = 32'h0;
        Product_lsb     = 1'b0;
        ALU_carry       = 1'b0;

        // Reset state while asserted, then idle with Run low
        #2;
        checkAll("reset_async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        checkOutput("reset_async.ADDU", 64'(ADDU_ctrl), 64'd0);
        tick();
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checkAll("idle_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);

        // Multiplicand 5, multiplier 3
        mplier = 32'd3;
        applyStimulus(1'b0, 32'd5);
        checkAll("run_start", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 32'd5);
        srlCycles = 0;
        for (int k = 0; k < 32; k++) begin
            Product_lsb = mplier[k];
            #1;
            checkOutput($sformatf("addu_iter%0d", k), 64'(ADDU_ctrl), 64'(k < 2));
            if (SRL_ctrl) srlCycles++;
            tick();
        end
        Product_lsb = 1'b1;
        #1;
        checkOutput("srl_cycles_x3", 64'(srlCycles), 64'd32);
        checkAll("done_x3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd32, 32'd5);
        checkOutput("done_x3.ADDU", 64'(ADDU_ctrl), 64'd0);
        Product_lsb = 1'b0;

        // Run in DONE is ignored
        Run = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        Run = 1'b0;
        checkAll("done_run_ignored", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd32, 32'd5);

        // Run held high for 40 cycles: one operation only
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Multiplicand_in = 32'h1234;
        Run = 1'b1;
        srlCycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (SRL_ctrl) srlCycles++;
        end
        Run = 1'b0;
        checkOutput("srl_cycles_held", 64'(srlCycles), 64'd32);
        checkAll("done_held", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd32, 32'h1234);

        // ALU carry at iteration 10
        applyStimulus(1'b1, 32'd7);
        for (int i = 0; i < 9; i++) tick();
        checkAll("pre_carry", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd9, 32'd7);
        ALU_carry = 1'b1;
        tick();
        ALU_carry = 1'b0;
        checkAll("carry_stop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd10, 32'd7);
        Run = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        Run = 1'b0;
        checkAll("carry_done_run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd10, 32'd7);

        // Reset at iteration 17, then a full run with all-ones multiplicand
        applyStimulus(1'b1, 32'hAA);
        for (int i = 0; i < 17; i++) tick();
        checkOutput("iter17.Count", 64'(Count), 64'd17);
        #3;
        Reset = 1'b1;
        #1;
        checkAll("mid_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        tick();
        Reset = 1'b0;
        applyStimulus(1'b0, 32'hFFFF_FFFF);
        srlCycles = 0;
        for (int k = 0; k < 32; k++) begin
            if (SRL_ctrl) srlCycles++;
            tick();
        end
        checkOutput("srl_cycles_ff", 64'(srlCycles), 64'd32);
        checkAll("done_ff", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd32, 32'hFFFF_FFFF);

        // Carry on the final iteration
        applyStimulus(1'b1, 32'd9);
        for (int i = 0; i < 31; i++) tick();
        checkAll("pre_last", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd31, 32'd9);
        ALU_carry = 1'b1;
        tick();
        ALU_carry = 1'b0;
        checkAll("carry_last", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd32, 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
